fifo_thresh: RTL
================

Name: fifo_thresh

Overview:
- Parametrised first-word-fall-through (FWFT) FIFO with the same valid/ready handshake on both sides.
- Adds a registered occupancy count, programmable almost-full and almost-empty flags, and sticky overflow/underflow error flags.
- Used as the general-purpose channel buffer between stream producers and consumers that need early back-pressure or a burst-ready indication.
- Storage is an inferred simple dual-port RAM with synchronous read, plus one output register.

Parameters:
- C_WIDTH, 32, data bus width in bits (>=1).
- C_DEPTH, 512, total capacity in entries, output register included; must be a power of two and >=4.
- C_CNT_W, clog2(C_DEPTH)+1, width of COUNT and of the threshold ports; derived, not overridden.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- WR_DATA  in  C_WIDTH  write data
- WR_VALID  in  1  write request
- WR_READY  out  1  space available (COUNT < C_DEPTH)
- RD_DATA  out  C_WIDTH  head-of-FIFO data, valid when RD_VALID
- RD_VALID  out  1  head data present
- RD_READY  in  1  consumer accepts head
- AF_THRESH  in  C_CNT_W  almost-full threshold; quasi-static
- AE_THRESH  in  C_CNT_W  almost-empty threshold; quasi-static
- COUNT  out  C_CNT_W  entries held (RAM plus output register), 0..C_DEPTH
- ALMOST_FULL  out  1  COUNT >= AF_THRESH
- ALMOST_EMPTY  out  1  COUNT <= AE_THRESH
- OVERFLOW  out  1  sticky: write attempted while full
- UNDERFLOW  out  1  sticky: RD_READY while ~RD_VALID
- ERR_CLR  in  1  clears OVERFLOW and UNDERFLOW

Behaviour:
- Reset values: WR_READY=1, RD_VALID=0, COUNT=0, ALMOST_FULL=(AF_THRESH==0), ALMOST_EMPTY=1, OVERFLOW=0, UNDERFLOW=0, RD_DATA=don't-care.
- Write accept: WR_VALID & WR_READY at edge k stores WR_DATA.
- Read accept: RD_VALID & RD_READY at edge k pops the head.
- Pointers: C_DEPTH-entry RAM, write/read pointers of clog2(C_DEPTH)+1 bits. The MSB distinguishes wrap. Pointers wrap modulo 2*C_DEPTH with no special case.
- Prefetch: the RAM is read whenever the output register will be empty after this edge (~RD_VALID, or a pop at this edge) and the RAM is non-empty.
- Latency, empty FIFO: a write accepted at edge k gives RD_VALID=1 after edge k+1 with that data on RD_DATA. There is no same-cycle bypass.
- Back-to-back pops: holding RD_READY=1 with data present delivers one entry per cycle, no bubbles.
- Hold on stall: RD_DATA and RD_VALID hold while RD_READY=0.
- COUNT is registered: COUNT_next = COUNT + wr_accept - rd_accept.
  - Simultaneous accept leaves COUNT unchanged.
  - COUNT counts entries in flight between RAM and output register.
- Full: WR_READY = ~(COUNT_next == C_DEPTH), registered.
  - At full, a simultaneous pop and write request: the write is not accepted that cycle (WR_READY is already 0). WR_READY returns to 1 on the following edge.
- ALMOST_FULL and ALMOST_EMPTY are registered, computed from COUNT_next, so they change on the same edge as COUNT.
  - AF_THRESH > C_DEPTH means ALMOST_FULL never asserts.
- OVERFLOW set on WR_VALID & ~WR_READY; UNDERFLOW set on RD_READY & ~RD_VALID. Neither changes FIFO state.
  - ERR_CLR clears both. If a set and ERR_CLR occur in the same cycle, set wins.
- Reset mid-operation: all contents are discarded and outputs return to reset values on the reset edge. Data presented during RST is ignored.

Optional Feature:
- Macro: FIFO_THRESH_FLUSH_EN.
- When defined: adds port FLUSH (in, 1).
  - FLUSH=1 at edge k sets both pointers equal, COUNT=0, RD_VALID=0, WR_READY=1, ALMOST_EMPTY=1.
  - Writes and reads in that cycle are discarded.
  - OVERFLOW and UNDERFLOW are preserved.
  - Normal operation resumes at edge k+1.
- When undefined: no FLUSH port; logic identical otherwise.

Test Plan:
- Fill/drain: C_DEPTH=8, write 0..7 with RD_READY=0 -> COUNT=8, WR_READY=0 after the 8th write. Then RD_READY=1 -> reads 0..7 in order on consecutive cycles, COUNT=0, RD_VALID=0.
- Latency: single write 0xA5 at edge k into empty FIFO -> RD_VALID=1, RD_DATA=0xA5 after edge k+1. COUNT=1 after edge k.
- Streaming at full: COUNT=8, WR_VALID=1 and RD_READY=1 for 20 cycles with random RD_READY drops -> no loss or duplication, COUNT stays 7..8, OVERFLOW stays 0 whenever WR_VALID respects WR_READY.
- Thresholds: AF_THRESH=6, AE_THRESH=2, write 6 -> ALMOST_EMPTY deasserts after the 3rd write, ALMOST_FULL asserts after the 6th write. Read 4 -> ALMOST_FULL clears after the 1st read, ALMOST_EMPTY sets after the 4th read.
- Errors: WR_VALID while full -> OVERFLOW=1, COUNT unchanged. RD_READY while empty -> UNDERFLOW=1. ERR_CLR pulse -> both 0. ERR_CLR together with a new overflow -> OVERFLOW stays 1.
- Reset/flush: COUNT=5 and RST=1 for one cycle -> COUNT=0, RD_VALID=0, WR_READY=1. Then (FIFO_THRESH_FLUSH_EN) COUNT=5 with FLUSH=1 -> same result, OVERFLOW preserved, and the next write is read back correctly after 2 edges.

Source files
------------

// File: rtl/fifo_thresh.sv
// fifo_thresh: first-word-fall-through FIFO with a valid/ready handshake on both
// sides. It adds a registered occupancy count, programmable almost-full and
// almost-empty flags, and sticky overflow/underflow error flags.
//
// Storage is a C_DEPTH-entry simple dual-port RAM with synchronous read. The
// RAM read register doubles as the output register, so RD_DATA comes straight
// from a flop. COUNT covers the RAM and the output register together.
//
// Optional feature: define FIFO_THRESH_FLUSH_EN to add a FLUSH input. FLUSH
// empties the FIFO in a single cycle and leaves the error flags untouched.
module fifo_thresh #(
  parameter int C_WIDTH = 32,
  parameter int C_DEPTH = 512
) (
  input  logic                     CLK,
  input  logic                     RST,
`ifdef FIFO_THRESH_FLUSH_EN
  input  logic                     FLUSH,
`endif
  input  logic [C_WIDTH-1:0]       WR_DATA,
  input  logic                     WR_VALID,
  output logic                     WR_READY,
  output logic [C_WIDTH-1:0]       RD_DATA,
  output logic                     RD_VALID,
  input  logic                     RD_READY,
  input  logic [$clog2(C_DEPTH):0] AF_THRESH,
  input  logic [$clog2(C_DEPTH):0] AE_THRESH,
  output logic [$clog2(C_DEPTH):0] COUNT,
  output logic                     ALMOST_FULL,
  output logic                     ALMOST_EMPTY,
  output logic                     OVERFLOW,
  output logic                     UNDERFLOW,
  input  logic                     ERR_CLR
);

  localparam int C_AW    = $clog2(C_DEPTH);
  localparam int C_CNT_W = C_AW + 1;
  localparam logic [C_CNT_W-1:0] C_FULL    = C_CNT_W'(C_DEPTH);
  localparam logic [C_AW:0]      C_PTR_ONE = (C_AW + 1)'(1);

  // Storage and pointers. The pointer MSB tells a full RAM from an empty one.
  logic [C_WIDTH-1:0] r_mem [C_DEPTH];
  logic [C_AW:0]      r_wptr;
  logic [C_AW:0]      r_rptr;

  // Output register and status registers.
  logic [C_WIDTH-1:0] r_rd_data;
  logic               r_rd_valid;
  logic               r_wr_ready;
  logic [C_CNT_W-1:0] r_count;
  logic               r_af;
  logic               r_ae;
  logic               r_ovf;
  logic               r_udf;

  logic               w_flush;
  logic               w_wr_acc;
  logic               w_rd_acc;
  logic               w_ram_empty;
  logic               w_rd_en;
  logic [C_CNT_W-1:0] w_count_next;

`ifdef FIFO_THRESH_FLUSH_EN
  assign w_flush = FLUSH;
`else
  assign w_flush = 1'b0;
`endif

  // Handshakes. Anything presented during reset or flush is dropped.
  assign w_wr_acc = WR_VALID & r_wr_ready & ~RST & ~w_flush;
  assign w_rd_acc = RD_READY & r_rd_valid & ~RST & ~w_flush;

  // Prefetch: refill the output register whenever it would be empty after this
  // edge and the RAM has something for it. Popping and refilling on the same
  // edge is what gives bubble-free streaming.
  assign w_ram_empty = (r_wptr == r_rptr);
  assign w_rd_en     = (~r_rd_valid | w_rd_acc) & ~w_ram_empty & ~RST & ~w_flush;

  // Occupancy after this edge; the flags are registered from it so they move
  // on the same edge as COUNT.
  assign w_count_next = r_count + C_CNT_W'(w_wr_acc) - C_CNT_W'(w_rd_acc);

  // RAM write port. There is no reset, so it can map onto block RAM.
  always_ff @(posedge CLK) begin
    if (w_wr_acc) r_mem[r_wptr[C_AW-1:0]] <= WR_DATA;
  end

  // RAM synchronous read into the output register. The value is held while stalled.
  // The read and write addresses never collide: the RAM cannot be full while
  // the output register is empty and a write is being accepted.
  always_ff @(posedge CLK) begin
    if (w_rd_en) r_rd_data <= r_mem[r_rptr[C_AW-1:0]];
  end

  // Pointer advance and output-register valid. Reset and flush both empty the FIFO.
  always_ff @(posedge CLK) begin
    if (RST || w_flush) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + C_PTR_ONE;
      if (w_rd_en) begin
        r_rptr     <= r_rptr + C_PTR_ONE;
        r_rd_valid <= 1'b1;
      end else if (w_rd_acc) begin
        r_rd_valid <= 1'b0;
      end
    end
  end

  // Registered occupancy, full indication and threshold flags.
  always_ff @(posedge CLK) begin
    if (RST || w_flush) begin
      r_count    <= '0;
      r_wr_ready <= 1'b1;
      r_ae       <= 1'b1;
      r_af       <= (AF_THRESH == '0);
    end else begin
      r_count    <= w_count_next;
      r_wr_ready <= (w_count_next != C_FULL);
      r_af       <= (w_count_next >= AF_THRESH);
      r_ae       <= (w_count_next <= AE_THRESH);
    end
  end

  // Sticky protocol-error flags. A new error wins over a clear in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (WR_VALID && !r_wr_ready) r_ovf <= 1'b1;
      else if (ERR_CLR)            r_ovf <= 1'b0;
      if (RD_READY && !r_rd_valid) r_udf <= 1'b1;
      else if (ERR_CLR)            r_udf <= 1'b0;
    end
  end

  assign WR_READY     = r_wr_ready;
  assign RD_DATA      = r_rd_data;
  assign RD_VALID     = r_rd_valid;
  assign COUNT        = r_count;
  assign ALMOST_FULL  = r_af;
  assign ALMOST_EMPTY = r_ae;
  assign OVERFLOW     = r_ovf;
  assign UNDERFLOW    = r_udf;

endmodule
